// File: rtl/timer.sv
// timer -- programmable interval timer for the LED pattern CPU core.
//
// A free-running prescaler divides clk into base ticks of TICK_DIV cycles.
// While startStop is high, the block counts `amount` base ticks and then
// raises `en` for one cycle. It then starts the next interval of the same
// length straight away, so a held startStop gives periodic pulses.
//
// Parameters:
//   COUNT_SIZE : prescaler width in bits.
//   TICK_DIV   : clock cycles per base tick, 1 .. 2**COUNT_SIZE.
//
// Ports:
//   clk       : system clock, rising edge active.
//   rst       : asynchronous, active-low reset.
//   startStop : 1 = run, 0 = stop and clear all counters.
//   amount    : interval length in base ticks; 0 means 256.
//   en        : registered expiry pulse.
//
// Handshake with the core: the core raises startStop to request an interval
// and holds it. en is the completion strobe; it is high for exactly one cycle
// per expiry. The core drops startStop on seeing en. A low startStop sampled
// at an edge clears the timer and forces en low on that same edge, so an
// aborted interval never produces a pulse.
module timer #(
  parameter int COUNT_SIZE = 26,
  parameter int TICK_DIV   = 3_125_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startStop,
  input  logic [7:0] amount,
  output logic       en
);

  localparam logic [COUNT_SIZE-1:0] PRESC_LAST = COUNT_SIZE'(TICK_DIV - 1);
  localparam logic [COUNT_SIZE-1:0] PRESC_ONE  = COUNT_SIZE'(1);

  logic [COUNT_SIZE-1:0] presc;
  logic [7:0]            units;
  logic [7:0]            units_next;

  // units wraps 255 -> 0, so amount == 0 matches only after 256 ticks.
  // amount is compared live at every tick rather than latched at start.
  assign units_next = units + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      units <= '0;
      en    <= 1'b0;
    end else if (!startStop) begin
      presc <= '0;
      units <= '0;
      en    <= 1'b0;
    end else if (presc != PRESC_LAST) begin
      presc <= presc + PRESC_ONE;
      en    <= 1'b0;
    end else begin
      presc <= '0;
      if (units_next == amount) begin
        units <= '0;
        en    <= 1'b1;
      end else begin
        units <= units_next;
        en    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer.sv
module tb_timer;

  localparam int COUNT_SIZE = 3;
  localparam int TICK_DIV   = 4;

  logic       clk;
  logic       rst;
  logic       startStop;
  logic [7:0] amount;
  logic       en;

  int checks   = 0;
  int failures = 0;

  // Reference model: number of consecutive running edges since the start
  // of the current run. With amount held constant during a run, en is
  // expected high after every edge whose count is a multiple of A*TICK_DIV.
  int   run_cnt = 0;
  logic exp_en  = 1'b0;

  logic [31:0] exp_q[$];

  timer #(
    .COUNT_SIZE(COUNT_SIZE),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .startStop(startStop),
    .amount   (amount),
    .en       (en)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    run_cnt = 0;
    exp_en  = 1'b0;
  endtask

  // One rising edge; the model consumes the inputs held across that edge,
  // then the outputs are sampled 1 ns later.
  task automatic cycle();
    int a;
    @(posedge clk);
    if (!rst || !startStop) begin
      model_clear();
    end else begin
      run_cnt++;
      a      = (amount == 8'd0) ? 256 : int'(amount);
      exp_en = ((run_cnt % (a * TICK_DIV)) == 0);
    end
    #1;
  endtask

  task automatic stop_dut();
    startStop = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; startStop = 1'b1; amount = 8'd3;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (en !== 1'b0) begin
        failures++;
        $display("FAIL reset_en edge=%0d got=%b want=0", i, en);
      end
      checks++;
      if (dut.presc !== 3'd0 || dut.units !== 8'd0) begin
        failures++;
        $display("FAIL reset_cnt edge=%0d presc=%0d units=%0d want=0/0", i, dut.presc, dut.units);
      end
    end
    // Release reset, let one pulse arrive, then reset between edges.
    rst = 1'b1; amount = 8'd1;
    for (int i = 1; i <= 4; i++) cycle();
    checks++;
    if (en !== 1'b1 || exp_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_prepulse got=%b want=1", en);
    end
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (en !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got=%b want=0", en);
    end
    #1;
    rst = 1'b1;
    stop_dut();
  endtask

  task automatic test_basic();
    amount = 8'd3; startStop = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      cycle();
      checks++;
      if (en !== exp_en || en !== (e == 12)) begin
        failures++;
        $display("FAIL basic edge=%0d got=%b want=%b", e, en, (e == 12));
      end
    end
    stop_dut();
  endtask

  task automatic test_periodic();
    logic [31:0] want;
    exp_q = {32'd8, 32'd16, 32'd24};
    amount = 8'd2; startStop = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      cycle();
      checks++;
      if (en !== exp_en) begin
        failures++;
        $display("FAIL periodic edge=%0d got=%b want=%b", e, en, exp_en);
      end
      if (en === 1'b1) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
        checks++;
        if (want !== 32'(e)) begin
          failures++;
          $display("FAIL periodic_pulse got_edge=%0d want_edge=%0d", e, want);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL periodic_missing got=%0d_left want=0_left", exp_q.size());
    end
    stop_dut();
  endtask

  task automatic test_abort();
    int pulse_edge = 0;
    amount = 8'd5; startStop = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      startStop = (e == 10 || e == 11) ? 1'b0 : 1'b1;
      cycle();
      checks++;
      if (en !== exp_en) begin
        failures++;
        $display("FAIL abort edge=%0d got=%b want=%b", e, en, exp_en);
      end
      if (en === 1'b1 && pulse_edge == 0) pulse_edge = e;
    end
    // Restart sampled at edge 12, so the first pulse is its 20th edge: 31.
    checks++;
    if (pulse_edge != 31) begin
      failures++;
      $display("FAIL abort_restart got_edge=%0d want_edge=31", pulse_edge);
    end
    stop_dut();
  endtask

  task automatic test_handshake();
    int first = 0;
    int extra = 0;
    amount = 8'd1; startStop = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      if (en === 1'b1) begin
        first = e;
        break;
      end
    end
    checks++;
    if (first != 4) begin
      failures++;
      $display("FAIL handshake_first got_edge=%0d want_edge=4", first);
    end
    startStop = 1'b0;
    cycle();
    checks++;
    if (en !== 1'b0) begin
      failures++;
      $display("FAIL handshake_drop got=%b want=0", en);
    end
    for (int e = 0; e < 10; e++) begin
      cycle();
      if (en === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL handshake_extra got=%0d want=0", extra);
    end
    stop_dut();
  endtask

  task automatic test_wrap();
    int first = 0;
    amount = 8'd0; startStop = 1'b1;
    for (int e = 1; e <= 1030; e++) begin
      cycle();
      if (en !== exp_en) begin
        checks++;
        failures++;
        $display("FAIL wrap edge=%0d got=%b want=%b", e, en, exp_en);
      end
      if (en === 1'b1 && first == 0) first = e;
    end
    checks++;
    if (first != 1024) begin
      failures++;
      $display("FAIL wrap_first got_edge=%0d want_edge=1024", first);
    end
    stop_dut();
  endtask

  task automatic test_random();
    int len;
    int gap;
    for (int r = 0; r < 8; r++) begin
      amount    = 8'($urandom_range(1, 5));
      startStop = 1'b1;
      len       = $urandom_range(1, 50);
      for (int e = 0; e < len; e++) begin
        cycle();
        checks++;
        if (en !== exp_en) begin
          failures++;
          $display("FAIL random run=%0d amount=%0d cnt=%0d got=%b want=%b", r, amount, run_cnt, en, exp_en);
        end
      end
      startStop = 1'b0;
      gap = $urandom_range(1, 3);
      for (int e = 0; e < gap; e++) begin
        cycle();
        checks++;
        if (en !== 1'b0) begin
          failures++;
          $display("FAIL random_stop run=%0d got=%b want=0", r, en);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; startStop = 1'b0; amount = 8'd0;
    #12;
    test_reset();
    test_basic();
    test_periodic();
    test_abort();
    test_handshake();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
